// File: rtl/uart_rx.sv
// uart_rx: 8N1/8E1/8O1 UART receiver with oversampling tick and error flags.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around the mid-bit sample point.
module uart_rx #(
    parameter int    ClkDivVal = 16,
    parameter string ParityBit = "none"
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_clk_en_i,
    input  logic       uart_rxd_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_error_o,
    output logic       frame_error_o
);
    localparam int TcW = $clog2(ClkDivVal);
    localparam logic [TcW-1:0] SmpPt = TcW'(ClkDivVal / 2);
    localparam logic [TcW-1:0] TcMax = TcW'(ClkDivVal - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [TcW-1:0] DecPt = SmpPt + 1'b1;
`else
    localparam logic [TcW-1:0] DecPt = SmpPt;
`endif
    localparam bit ParEn  = (ParityBit != "none");
    localparam bit ParOdd = (ParityBit == "odd");

    typedef enum logic [2:0] {idle_e, startbit_e, databits_e, paritybit_e, stopbit_e} state_t;

    state_t         state_q, state_d;
    logic [1:0]     sync_q, sync_d;
    logic [TcW-1:0] tc_q, tc_d;
    logic [2:0]     bit_q, bit_d;
    logic           armed_q, armed_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           rxd_s, dec, wrap, bit_v;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0]     smp_q, smp_d;
`endif

    assign rxd_s = sync_q[1];
    assign dec   = uart_clk_en_i && (tc_q == DecPt);
    assign wrap  = uart_clk_en_i && (tc_q == TcMax);
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign bit_v = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);
`else
    assign bit_v = rxd_s;
`endif

    always_comb begin
        sync_d  = {sync_q[0], uart_rxd_i};
        state_d = state_q;
        tc_d    = tc_q;
        bit_d   = bit_q;
        armed_d = armed_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        smp_d    = smp_q;
        smp_d[0] = (uart_clk_en_i && tc_q == SmpPt - 1'b1) ? rxd_s : smp_q[0];
        smp_d[1] = (uart_clk_en_i && tc_q == SmpPt) ? rxd_s : smp_q[1];
`endif
        if (uart_clk_en_i) tc_d = wrap ? '0 : tc_q + 1'b1;
        case (state_q)
            idle_e: begin
                tc_d = '0;
                if (rxd_s) armed_d = 1'b1;
                else if (armed_q) state_d = startbit_e;
            end
            startbit_e: begin
                if (dec && bit_v) state_d = idle_e;
                else if (wrap) begin
                    state_d = databits_e;
                    bit_d   = '0;
                end
            end
            databits_e: begin
                if (dec) shift_d = {bit_v, shift_q[7:1]};
                if (wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ParEn ? paritybit_e : stopbit_e;
                end
            end
            paritybit_e: begin
                if (dec) par_d = bit_v;
                if (wrap) state_d = stopbit_e;
            end
            stopbit_e: begin
                // Leaving at mid-stop-bit gives half a bit of slack for rate mismatch
                if (dec) begin
                    state_d = idle_e;
                    armed_d = 1'b0;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    ferr_d  = ~bit_v;
                    perr_d  = ParEn && (par_q != (^shift_q ^ ParOdd));
                end
            end
            default: state_d = idle_e;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= idle_e;
            sync_q  <= 2'b11;
            tc_q    <= '0;
            bit_q   <= '0;
            armed_q <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            smp_q   <= 2'b11;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tc_q    <= tc_d;
            bit_q   <= bit_d;
            armed_q <= armed_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            smp_q   <= smp_d;
`endif
        end
    end

    assign data_o         = data_q;
    assign data_valid_o   = valid_q;
    assign parity_error_o = perr_q;
    assign frame_error_o  = ferr_q;
endmodule
